device2_rx_lane: RTL and testbench
==================================

# device2_rx_lane

Receive lane of device 2 in the adaptive PCIe switch. It takes one serial lane driven by device 1 (`out0` or `out1`) and aligns word boundaries on a sync pattern. It deserializes MSB-first 10-bit words and buffers the non-idle words in a FIFO. The FIFO's almost-full flag is the back-pressure signal that device 1 consumes as `fifo0_disp2_almostfull` / `fifo1_disp2_almostfull`; one instance is built per lane.

## Interface
Parameters:
- `DATA_SIZE`, 10: word width, in bits.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of 2.
- `AF_THRESH`, 6: `fifo_almostfull` asserts when occupancy ≥ this value.
- `SYNC_WORD`, 10'h3BC: alignment/idle pattern.
- `SYNC_COUNT`, 4: number of consecutive aligned sync words needed to reach lock.

Ports:
- `clk` in 1: single clock, the serial bit clock (8f domain). All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `serial_in` in 1: lane bit stream, one bit per `clk`.
- `pop` in 1: read request from the downstream consumer.
- `data_out` out `DATA_SIZE`: popped word, registered.
- `data_valid` out 1: `data_out` holds a freshly popped word.
- `fifo_empty` out 1: FIFO occupancy = 0.
- `fifo_full` out 1: FIFO occupancy = `FIFO_DEPTH`.
- `fifo_almostfull` out 1: occupancy ≥ `AF_THRESH`; drives device 1's almostfull input.
- `locked` out 1: alignment FSM is in LOCKED.
- `error_overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `error_underflow` out 1: one-cycle pulse; `pop` arrived while the FIFO was empty.

## Operation
- Shift register `sh[DATA_SIZE-2:0]` captures one bit per cycle. The current window is `{sh, serial_in}`.
- FSM states, reset to HUNT:
  - HUNT: compares the window every cycle. On a match with `SYNC_WORD` it goes to SYNC, sets `bit_cnt`=0 and `sync_cnt`=1.
  - SYNC: `bit_cnt` counts 0..9 and wraps. When `bit_cnt`=9 the window is a word:
    - If the word = `SYNC_WORD`, `sync_cnt`++. When `sync_cnt` reaches `SYNC_COUNT` the FSM goes to LOCKED.
    - Any other word sends the FSM back to HUNT.
  - LOCKED: at each `bit_cnt`=9 the word completes:
    - `SYNC_WORD` is idle and is discarded.
    - Any other word is pushed to the FIFO.
  - Outside LOCKED, nothing is pushed.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and an occupancy counter of `log2(FIFO_DEPTH)+1` bits.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push while `fifo_full` (the state before the edge) drops the word and sets `error_overflow`, even when a pop occurs in the same cycle.
- Pop:
  - `pop` with `!fifo_empty` loads the head entry into `data_out` and pulses `data_valid` for one cycle.
  - `pop` while empty leaves `data_out` unchanged and pulses `error_underflow`, even when a push occurs in the same cycle.
- Simultaneous push and pop with a FIFO that is neither empty nor full: both take effect and occupancy is unchanged.
- `error_overflow` clears only on reset.
- Reset, async, also mid-word or mid-lock: every output clears at once.
  - `data_out`=0, `data_valid`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_almostfull`=0, `locked`=0, both errors 0.
  - FSM goes to HUNT; `sh`, counters and pointers go to 0.

## Timing
- Serial to FIFO: the last (LSB) bit of a word sampled at edge k is written at edge k. `fifo_empty` falls after edge k.
- Pop latency is 1 cycle: `pop` high before edge k gives `data_out`/`data_valid` valid after edge k.
- Status flags are registered and reflect occupancy after the same edge.
- `fifo_almostfull` rises after the edge that makes occupancy = `AF_THRESH` and falls after the edge that drops it below.
- Lock time from a clean stream: `SYNC_COUNT` × 10 bits after the first sync bit. `locked` rises after the edge completing the last sync word.

## Configuration
- `DEVICE2_LOS_DETECT_EN` defined: loss-of-sync watchdog.
  - A 6-bit counter in LOCKED counts completed words since the last `SYNC_WORD`.
  - When it reaches 63, the FSM returns to HUNT, `locked` falls, and the word completing at that edge is not pushed.
  - The counter resets on every sync word and on reset.
- Undefined: no watchdog; LOCKED is left only by reset.

## Test plan
- Reset: assert `reset` asynchronously mid-word while the FIFO holds 3 words. All outputs take their reset values immediately, with no clock edge; `locked`=0.
- Lock: send 4×10'h3BC followed by 10'h155.
  - `locked`=1 after bit 40.
  - 10'h155 is in the FIFO after bit 50; `fifo_empty`=0.
  - `pop` gives `data_out`=10'h155, `data_valid`=1 one cycle later.
- Misalignment: send 2×10'h3BC, then 10'h2AA, then 4×10'h3BC.
  - The FSM returns to HUNT at the 10'h2AA word.
  - `locked` rises only after the last of the four later syncs.
- Back-pressure and overflow: once locked, push 9 non-sync words with no pops.
  - `fifo_almostfull` rises after word 6; `fifo_full` after word 8.
  - Word 9 is dropped, `error_overflow`=1, occupancy stays 8.
- Underflow and concurrency:
  - `pop` on an empty FIFO: one-cycle `error_underflow`, `data_out` unchanged.
  - Push and pop in the same cycle at occupancy 4: occupancy stays 4 and FIFO order is preserved.
- `DEVICE2_LOS_DETECT_EN`: locked, then 63 non-sync words.
  - `locked` falls after word 63, which is not pushed.
  - Without the macro, `locked` stays 1.

Source files
------------

// File: rtl/device2_rx_lane.sv
// -----------------------------------------------------------------------------
// device2_rx_lane
//
// Receive lane of device 2. It finds word boundaries on a serial bit stream by
// hunting for SYNC_WORD, and needs SYNC_COUNT consecutive aligned sync words
// before it declares lock. Once locked, it deserializes MSB-first words and
// pushes every non-idle word into a small circular FIFO. The FIFO's
// almost-full flag is the back-pressure signal returned to device 1.
//
// Optional feature (macro DEVICE2_LOS_DETECT_EN):
//   Loss-of-sync watchdog. While LOCKED, a run of 63 completed words with no
//   SYNC_WORD among them drops the lane back to HUNT. The 63rd word is not
//   pushed. Without the macro, only reset leaves LOCKED.
//
// Parameters:
//   DATA_SIZE   word width in bits
//   FIFO_DEPTH  FIFO entries (power of 2)
//   AF_THRESH   occupancy at or above which fifo_almostfull is high
//   SYNC_WORD   alignment / idle pattern
//   SYNC_COUNT  aligned sync words needed to reach lock (>= 2)
//
// Ports:
//   clk             serial bit clock, rising edge
//   reset           asynchronous, active-high
//   serial_in       lane bit stream, one bit per clk
//   pop             read request from the consumer
//   data_out        popped word (registered)
//   data_valid      one-cycle strobe: data_out was just loaded
//   fifo_empty      occupancy == 0
//   fifo_full       occupancy == FIFO_DEPTH
//   fifo_almostfull occupancy >= AF_THRESH
//   locked          alignment FSM is in LOCKED
//   error_overflow  sticky: a word was dropped because the FIFO was full
//   error_underflow one-cycle pulse: pop while the FIFO was empty
// -----------------------------------------------------------------------------
module device2_rx_lane #(
   parameter int                   DATA_SIZE  = 10,
   parameter int                   FIFO_DEPTH = 8,
   parameter int                   AF_THRESH  = 6,
   parameter logic [DATA_SIZE-1:0] SYNC_WORD  = 10'h3BC,
   parameter int                   SYNC_COUNT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 data_valid,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 fifo_almostfull,
   output logic                 locked,
   output logic                 error_overflow,
   output logic                 error_underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_SIZE);
   localparam int SW = $clog2(SYNC_COUNT + 1);

   localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_SIZE - 1);
   localparam logic [SW-1:0] SYNC_TARGET = SW'(SYNC_COUNT);
   localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   AF_C        = (AW + 1)'(AF_THRESH);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t                 state, state_nx;
   logic [DATA_SIZE-2:0]   sh;
   logic [DATA_SIZE-1:0]   window;
   logic [BW-1:0]          bit_cnt, bit_cnt_nx;
   logic [SW-1:0]          sync_cnt, sync_cnt_nx;
   logic                   word_done;
   logic                   push;
   logic                   push_ok;
   logic                   pop_ok;

`ifdef DEVICE2_LOS_DETECT_EN
   logic [5:0]             los_cnt, los_cnt_nx;
`endif

   logic [DATA_SIZE-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            count;

   // The bit arriving this cycle completes the window, so a word is usable
   // at the same edge that samples its LSB.
   assign window    = {sh, serial_in};
   assign word_done = (bit_cnt == LAST_BIT);

   // ---- alignment FSM: state register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= HUNT;
         sh       <= '0;
         bit_cnt  <= '0;
         sync_cnt <= '0;
`ifdef DEVICE2_LOS_DETECT_EN
         los_cnt  <= '0;
`endif
      end else begin
         state    <= state_nx;
         sh       <= window[DATA_SIZE-2:0];
         bit_cnt  <= bit_cnt_nx;
         sync_cnt <= sync_cnt_nx;
`ifdef DEVICE2_LOS_DETECT_EN
         los_cnt  <= los_cnt_nx;
`endif
      end
   end

   // ---- alignment FSM: next state and push decision ----
   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      sync_cnt_nx = sync_cnt;
      push        = 1'b0;
`ifdef DEVICE2_LOS_DETECT_EN
      los_cnt_nx  = '0;
`endif
      unique case (state)
         HUNT: begin
            // Slide over every bit position until the pattern shows up.
            bit_cnt_nx  = '0;
            sync_cnt_nx = '0;
            if (window == SYNC_WORD) begin
               state_nx    = SYNC;
               sync_cnt_nx = SW'(1);
            end
         end
         SYNC: begin
            if (word_done) begin
               bit_cnt_nx = '0;
               if (window == SYNC_WORD) begin
                  sync_cnt_nx = sync_cnt + SW'(1);
                  if (sync_cnt + SW'(1) == SYNC_TARGET) begin
                     state_nx = LOCKED;
                  end
               end else begin
                  state_nx    = HUNT;
                  sync_cnt_nx = '0;
               end
            end else begin
               bit_cnt_nx = bit_cnt + BW'(1);
            end
         end
         LOCKED: begin
`ifdef DEVICE2_LOS_DETECT_EN
            los_cnt_nx = los_cnt;
`endif
            if (word_done) begin
               bit_cnt_nx = '0;
               if (window == SYNC_WORD) begin
`ifdef DEVICE2_LOS_DETECT_EN
                  los_cnt_nx = '0;
`endif
               end else begin
`ifdef DEVICE2_LOS_DETECT_EN
                  // 63rd word without an idle: give up alignment and drop it.
                  if (los_cnt == 6'd62) begin
                     state_nx   = HUNT;
                     los_cnt_nx = '0;
                  end else begin
                     los_cnt_nx = los_cnt + 6'd1;
                     push       = 1'b1;
                  end
`else
                  push = 1'b1;
`endif
               end
            end else begin
               bit_cnt_nx = bit_cnt + BW'(1);
            end
         end
         default: begin
            state_nx    = HUNT;
            bit_cnt_nx  = '0;
            sync_cnt_nx = '0;
         end
      endcase
   end

   assign locked = (state == LOCKED);

   // ---- FIFO ----
   // Full/empty are judged on the state before the edge, so a push into a
   // full FIFO is dropped even if a pop frees a slot in the same cycle.
   assign push_ok = push && !fifo_full;
   assign pop_ok  = pop  && !fifo_empty;

   assign fifo_empty      = (count == '0);
   assign fifo_full       = (count == DEPTH_C);
   assign fifo_almostfull = (count >= AF_C);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= window;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         data_out        <= '0;
         data_valid      <= 1'b0;
         error_overflow  <= 1'b0;
         error_underflow <= 1'b0;
      end else begin
         data_valid      <= pop_ok;
         error_underflow <= pop && fifo_empty;
         if (push && fifo_full) begin
            error_overflow <= 1'b1;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_device2_rx_lane.sv
`timescale 1ns/1ps
module tb_device2_rx_lane;

   localparam int         DW     = 10;
   localparam int         DEPTH  = 8;
   localparam int         AFT    = 6;
   localparam int         SCOUNT = 4;
   localparam logic [9:0] SYNCW  = 10'h3BC;
`ifdef DEVICE2_LOS_DETECT_EN
   localparam bit LOS_EN = 1'b1;
`else
   localparam bit LOS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          serial_in = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid, fifo_empty, fifo_full, fifo_almostfull;
   logic          locked, error_overflow, error_underflow;

   int errors = 0;
   int checks = 0;

   device2_rx_lane #(
      .DATA_SIZE (DW),
      .FIFO_DEPTH(DEPTH),
      .AF_THRESH (AFT),
      .SYNC_WORD (SYNCW),
      .SYNC_COUNT(SCOUNT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .serial_in      (serial_in),
      .pop            (pop),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .fifo_empty     (fifo_empty),
      .fifo_full      (fifo_full),
      .fifo_almostfull(fifo_almostfull),
      .locked         (locked),
      .error_overflow (error_overflow),
      .error_underflow(error_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 searching, 1 confirming alignment, 2 locked
   int         m_win   = 0;
   int         m_mode  = 0;
   int         m_phase = 0;
   int         m_nsync = 0;
   int         m_quiet = 0;
   logic [9:0] q[$];
   logic [9:0] m_dout = '0;
   bit         m_dv = 0, m_ovf = 0, m_ufl = 0;

   task automatic model_reset();
      m_win = 0; m_mode = 0; m_phase = 0; m_nsync = 0; m_quiet = 0;
      q.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_ufl = 0;
   endtask

   task automatic model_step(input logic b, input logic p);
      logic [9:0] w;
      bit         do_push, was_full, was_empty;
      m_win = ((m_win << 1) | int'(b)) & 'h3FF;
      w = m_win[9:0];
      do_push = 0;
      if (m_mode == 0) begin
         if (w == SYNCW) begin
            m_mode = 1; m_phase = 0; m_nsync = 1;
         end
      end else begin
         m_phase++;
         if (m_phase == DW) begin
            m_phase = 0;
            if (m_mode == 1) begin
               if (w == SYNCW) begin
                  m_nsync++;
                  if (m_nsync == SCOUNT) begin
                     m_mode = 2; m_quiet = 0;
                  end
               end else begin
                  m_mode = 0;
               end
            end else begin
               if (w == SYNCW) m_quiet = 0;
               else if (LOS_EN && m_quiet == 62) m_mode = 0;
               else begin
                  m_quiet++;
                  do_push = 1;
               end
            end
         end
      end
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ufl = p && was_empty;
      m_dv  = 0;
      if (p && !was_empty) begin
         m_dout = q.pop_front();
         m_dv   = 1;
      end
      if (do_push) begin
         if (was_full) m_ovf = 1;
         else q.push_back(w);
      end
   endtask

   task automatic compare();
      check("data_out", data_out, m_dout);
      check("data_valid", data_valid, m_dv);
      check("fifo_empty", fifo_empty, q.size() == 0);
      check("fifo_full", fifo_full, q.size() == DEPTH);
      check("fifo_almostfull", fifo_almostfull, q.size() >= AFT);
      check("locked", locked, m_mode == 2);
      check("error_overflow", error_overflow, m_ovf);
      check("error_underflow", error_underflow, m_ufl);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else model_step(serial_in, pop);
      #1;
      compare();
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic b, input logic p);
      @(negedge clk);
      serial_in = b;
      pop = p;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [9:0] w, input logic [9:0] popmask);
      for (int j = 0; j < DW; j++) tick(w[9-j], popmask[j]);
   endtask

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = 10'($urandom); while (w == SYNCW);
      return w;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_data_out"}, data_out, 0);
      check({tag, "_data_valid"}, data_valid, 0);
      check({tag, "_fifo_empty"}, fifo_empty, 1);
      check({tag, "_fifo_full"}, fifo_full, 0);
      check({tag, "_fifo_af"}, fifo_almostfull, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_ovf"}, error_overflow, 0);
      check({tag, "_ufl"}, error_underflow, 0);
   endtask

   // Reset lands between clock edges; outputs are checked before any edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values(tag);
      @(negedge clk);
      serial_in = 1'b0;
      pop = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] d[10];
      logic [9:0] cur;
      int         pct, r, n;

      #1;
      check_reset_values("por");
      @(negedge clk);
      reset = 1'b0;
      repeat (5) tick(1'b0, 1'b0);

      // Lock from a clean stream, then one data word.
      for (int i = 0; i < 4; i++) begin
         send_word(SYNCW, '0);
         if (i == 2) check("locked_after_3_syncs", locked, 0);
      end
      check("locked_after_4_syncs", locked, 1);
      check("empty_before_data", fifo_empty, 1);
      send_word(10'h155, '0);
      check("empty_after_155", fifo_empty, 0);
      cur = SYNCW;
      tick(cur[9], 1'b1);
      check("pop_155_data", data_out, 10'h155);
      check("pop_155_valid", data_valid, 1);
      tick(cur[8], 1'b1);
      check("underflow_pulse", error_underflow, 1);
      check("underflow_data_kept", data_out, 10'h155);
      check("underflow_valid", data_valid, 0);
      tick(cur[7], 1'b0);
      check("underflow_cleared", error_underflow, 0);
      for (int j = 3; j < DW; j++) tick(cur[9-j], 1'b0);

      // Fill without pops: almost-full, full, then overflow.
      for (int k = 0; k < 9; k++) begin
         d[k] = rand_data();
         send_word(d[k], '0);
         if (k == 4) check("af_after_5", fifo_almostfull, 0);
         if (k == 5) check("af_after_6", fifo_almostfull, 1);
         if (k == 6) check("full_after_7", fifo_full, 0);
         if (k == 7) begin
            check("full_after_8", fifo_full, 1);
            check("ovf_after_8", error_overflow, 0);
         end
      end
      check("ovf_after_9", error_overflow, 1);
      check("full_after_9", fifo_full, 1);
      send_word(SYNCW, 10'b0000011111);
      check("pop5_data", data_out, d[4]);
      check("pop5_not_full", fifo_full, 0);
      check("pop5_af", fifo_almostfull, 0);
      check("ovf_sticky", error_overflow, 1);

      // Reset mid-word with three words buffered.
      repeat (4) tick(1'b1, 1'b0);
      async_reset("midword_rst");
      repeat (3) tick(1'b0, 1'b0);

      // Misalignment: the odd word forces a fresh four-sync acquisition.
      send_word(SYNCW, '0);
      send_word(SYNCW, '0);
      send_word(10'h2AA, '0);
      check("locked_after_2aa", locked, 0);
      for (int i = 0; i < 3; i++) send_word(SYNCW, '0);
      check("locked_after_3_later", locked, 0);
      send_word(SYNCW, '0);
      check("locked_after_4_later", locked, 1);

      // Push and pop together at occupancy 4.
      for (int k = 0; k < 5; k++) d[k] = rand_data();
      for (int k = 0; k < 4; k++) send_word(d[k], '0);
      send_word(d[4], 10'b1000000000);
      check("concurrent_pop_data", data_out, d[0]);
      check("concurrent_valid", data_valid, 1);
      check("concurrent_not_af", fifo_almostfull, 0);
      cur = SYNCW;
      for (int j = 0; j < DW; j++) begin
         tick(cur[9-j], j < 4);
         if (j < 4) check("order_data", data_out, d[j+1]);
      end
      check("order_drained", fifo_empty, 1);

      // Long run without idles.
      for (int k = 0; k < 63; k++) begin
         send_word(rand_data(), 10'b0000100000);
         if (k == 61) check("los_locked_62", locked, 1);
      end
      check("los_locked_63", locked, LOS_EN ? 0 : 1);
      check("los_word63_dropped", fifo_empty, LOS_EN ? 1 : 0);

      // Randomized segments with varying consumer rates.
      for (int seg = 0; seg < 12; seg++) begin
         if (seg % 3 == 0) async_reset("seg_rst");
         case (seg % 4)
            0: pct = 0;
            1: pct = 5;
            2: pct = 20;
            default: pct = 50;
         endcase
         repeat (150) begin
            r = $urandom_range(0, 99);
            if (r < 45) cur = SYNCW;
            else cur = 10'($urandom);
            if (r >= 95) begin
               n = $urandom_range(1, 3);
               for (int j = 0; j < n; j++)
                  tick(1'($urandom), $urandom_range(0, 99) < pct);
            end else begin
               for (int j = 0; j < DW; j++)
                  tick(cur[9-j], $urandom_range(0, 99) < pct);
            end
         end
      end

      repeat (2) tick(1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
